fc_batch_sequencer: RTL and testbench
=====================================

FC_BATCH_SEQUENCER -- requirements
Module: fc_batch_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): FRT_CELL, 14, flatten/input cells; MID_CELL, 10, hidden cells; BCK_CELL, 5, output cells; BATCH_SIZE, 32, samples per mini-batch.
REQ-002 Derived word counts SHALL be W1_WORDS=FRT_CELL*MID_CELL, W2_WORDS=MID_CELL*BCK_CELL, IN_WORDS=FRT_CELL, ANS_WORDS=BCK_CELL.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a batch (one-cycle pulse)
- load_weights  in  1  sampled with start: 1 = load W1 and W2 first, 0 = reuse resident weights
- s_valid  in  1  upstream word valid
- s_data  in  16  upstream word
- s_ready  out  1  word accepted when s_valid&&s_ready
- weight1  out  1  FC weight1 load select
- weight2  out  1  FC weight2 load select
- right_answer  out  1  answer load select
- enable  out  1  FC forward run
- ex_we  out  1  external write enable
- ex_value  out  16  external write data
- ex_addr  out  16  external write address
- bck_prop_start  out  1  back-propagation start pulse
- batch_end  out  1  mini-batch end pulse
- all_end  in  1  FC forward finished
- fc_bck_prop_end  in  1  back-propagation finished
- fc_batch_end  in  1  batch weight update finished
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, batch complete
- error  out  1  sticky watchdog flag (see REQ-019)
- sample_cnt  out  6  samples finished in current batch

Function
REQ-004 FSM states SHALL be IDLE, LD_W1, LD_W2, LD_IN, LD_ANS, RUN, BPROP, BEND, DONE.
REQ-005 IDLE: start=1 SHALL go to LD_W1 if load_weights=1, else LD_IN; sample_cnt cleared; start ignored in any other state.
REQ-006 Load states: s_ready=1; ex_we=s_valid; ex_value=s_data; ex_addr=word counter (zero at state entry, +1 per accepted word); no transfer when s_valid=0.
REQ-007 Word count per state SHALL be W1_WORDS, W2_WORDS, IN_WORDS, ANS_WORDS; on the last accepted word the FSM SHALL advance next cycle (LD_W1->LD_W2->LD_IN->LD_ANS->RUN).
REQ-008 weight1=1 only in LD_W1, weight2=1 only in LD_W2, right_answer=1 only in LD_ANS; all 0 in LD_IN; at most one of weight1/weight2/right_answer/enable high in any cycle.
REQ-009 s_ready, ex_we SHALL be 0 outside load states; ex_value, ex_addr SHALL be 0 when ex_we=0.
REQ-010 RUN: enable=1 from entry until the cycle all_end is sampled 1; next cycle state=BPROP, enable=0.
REQ-011 BPROP: bck_prop_start=1 for exactly the first cycle; on fc_bck_prop_end=1, sample_cnt+1; if new count=BATCH_SIZE go to BEND, else LD_IN.
REQ-012 fc_bck_prop_end asserted in the same cycle as the bck_prop_start pulse SHALL be accepted.
REQ-013 BEND: batch_end=1 first cycle only; on fc_batch_end=1 go to DONE.
REQ-014 DONE: done=1 for one cycle, then IDLE; sample_cnt holds BATCH_SIZE until next start.
REQ-015 all_end, fc_bck_prop_end, fc_batch_end outside their waiting state SHALL be ignored.
REQ-016 All outputs registered or decoded from state/counters only; no combinational path s_valid->s_ready.

Reset
REQ-017 reset=1 at any clock edge, including mid-load or mid-run, SHALL force IDLE, clear all counters and error, and drive every output to 0 on the following cycle; in-flight words are dropped.

Configuration
REQ-018 Macro FC_SEQ_WATCHDOG_EN SHALL compile in a 16-bit watchdog.
REQ-019 Defined: counter clears on entry to RUN/BPROP/BEND, counts while waiting; at 65535 FSM goes to IDLE, error=1 (sticky until reset or start), done not pulsed. Undefined: no counter, error tied 0, waits unbounded.

Verification
REQ-020 start, load_weights=1, continuous s_valid -> 140 ex_we with weight1=1 (addr 0..139), 50 with weight2=1, 14 plain, 5 with right_answer=1, then enable=1.
REQ-021 load_weights=0, BATCH_SIZE=2, all_end/fc_bck_prop_end/fc_batch_end each 3 cycles after request -> exactly 2 bck_prop_start pulses, 1 batch_end pulse, done pulse, sample_cnt=2.
REQ-022 s_valid toggling 1/0 during LD_IN -> ex_addr increments only on accepted words, 14 writes total.
REQ-023 reset=1 during RUN at sample 5 -> next cycle enable=0, busy=0, sample_cnt=0; subsequent start completes normally.
REQ-024 FC_SEQ_WATCHDOG_EN defined, all_end never asserted -> after 65535 RUN cycles: error=1, busy=0, done=0.

Source files
------------

// File: rtl/fc_batch_sequencer.sv
// Mini-batch sequencer for the FC block: weight/input/answer load, run, backprop, batch update.
// Define FC_SEQ_WATCHDOG_EN to compile in a 16-bit watchdog on the FC wait states.
module fc_batch_sequencer #(
    parameter int FRT_CELL   = 14,
    parameter int MID_CELL   = 10,
    parameter int BCK_CELL   = 5,
    parameter int BATCH_SIZE = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        load_weights,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic        weight1,
    output logic        weight2,
    output logic        right_answer,
    output logic        enable,
    output logic        ex_we,
    output logic [15:0] ex_value,
    output logic [15:0] ex_addr,
    output logic        bck_prop_start,
    output logic        batch_end,
    input  logic        all_end,
    input  logic        fc_bck_prop_end,
    input  logic        fc_batch_end,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  sample_cnt
);
    localparam int W1_WORDS  = FRT_CELL * MID_CELL;
    localparam int W2_WORDS  = MID_CELL * BCK_CELL;
    localparam int IN_WORDS  = FRT_CELL;
    localparam int ANS_WORDS = BCK_CELL;

    typedef enum logic [3:0] {
        IDLE, LD_W1, LD_W2, LD_IN, LD_ANS, RUN, BPROP, BEND, DONE
    } state_t;

    state_t      state, state_nx;
    logic [15:0] word_cnt;
    logic [15:0] word_last;
    logic        first_q;
    logic [5:0]  sample_q;
    logic [5:0]  sample_inc;
    logic        error_q;
    logic        load_st;
    logic        accept;
    logic        last_word;
    logic        waiting;
    logic        wd_hit;
    logic        wd_trip;

    always_comb begin
        load_st   = 1'b0;
        word_last = '0;
        case (state)
            LD_W1: begin
                load_st   = 1'b1;
                word_last = 16'(W1_WORDS - 1);
            end
            LD_W2: begin
                load_st   = 1'b1;
                word_last = 16'(W2_WORDS - 1);
            end
            LD_IN: begin
                load_st   = 1'b1;
                word_last = 16'(IN_WORDS - 1);
            end
            LD_ANS: begin
                load_st   = 1'b1;
                word_last = 16'(ANS_WORDS - 1);
            end
            default: ;
        endcase
    end

    assign accept     = load_st & s_valid;
    assign last_word  = accept && (word_cnt == word_last);
    assign sample_inc = sample_q + 6'd1;
    assign waiting    = (state == RUN) || (state == BPROP) || (state == BEND);

`ifdef FC_SEQ_WATCHDOG_EN
    logic [15:0] wd_cnt;

    assign wd_hit = (wd_cnt == 16'hFFFF);

    always_ff @(posedge clk) begin
        if (reset)
            wd_cnt <= '0;
        else if (state_nx != state)
            wd_cnt <= '0;
        else if (waiting)
            wd_cnt <= wd_cnt + 16'd1;
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        wd_trip  = 1'b0;
        case (state)
            IDLE:
                if (start)
                    state_nx = load_weights ? LD_W1 : LD_IN;
            LD_W1:  if (last_word) state_nx = LD_W2;
            LD_W2:  if (last_word) state_nx = LD_IN;
            LD_IN:  if (last_word) state_nx = LD_ANS;
            LD_ANS: if (last_word) state_nx = RUN;
            RUN:
                if (all_end)
                    state_nx = BPROP;
                else if (wd_hit)
                    wd_trip = 1'b1;
            BPROP:
                if (fc_bck_prop_end)
                    state_nx = (sample_inc == 6'(BATCH_SIZE)) ? BEND : LD_IN;
                else if (wd_hit)
                    wd_trip = 1'b1;
            BEND:
                if (fc_batch_end)
                    state_nx = DONE;
                else if (wd_hit)
                    wd_trip = 1'b1;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (wd_trip)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            first_q  <= 1'b0;
            sample_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            // marks the first cycle of every state for the single-cycle pulses
            first_q <= (state_nx != state);
            if (state_nx != state)
                word_cnt <= '0;
            else if (accept)
                word_cnt <= word_cnt + 16'd1;
            if (state == IDLE && start)
                sample_q <= '0;
            else if (state == BPROP && fc_bck_prop_end)
                sample_q <= sample_inc;
            if (state == IDLE && start)
                error_q <= 1'b0;
            else if (wd_trip)
                error_q <= 1'b1;
        end
    end

    assign s_ready        = load_st;
    assign ex_we          = accept;
    assign ex_value       = accept ? s_data : 16'd0;
    assign ex_addr        = accept ? word_cnt : 16'd0;
    assign weight1        = (state == LD_W1);
    assign weight2        = (state == LD_W2);
    assign right_answer   = (state == LD_ANS);
    assign enable         = (state == RUN);
    assign bck_prop_start = (state == BPROP) && first_q;
    assign batch_end      = (state == BEND) && first_q;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign error          = error_q;
    assign sample_cnt     = sample_q;
endmodule

// File: tb/tb_fc_batch_sequencer.sv
// Directed bench for fc_batch_sequencer with a delayed-handshake FC responder.
// Runs the watchdog scenario when FC_SEQ_WATCHDOG_EN is defined.
module tb_fc_batch_sequencer;
    localparam int BS = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        load_weights = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = 16'h0000;
    logic        s_ready, weight1, weight2, right_answer, enable;
    logic        ex_we;
    logic [15:0] ex_value, ex_addr;
    logic        bck_prop_start, batch_end;
    logic        all_end = 1'b0;
    logic        fc_bck_prop_end = 1'b0;
    logic        fc_batch_end = 1'b0;
    logic        busy, done, error;
    logic [5:0]  sample_cnt;

    fc_batch_sequencer #(.BATCH_SIZE(BS)) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_weights(load_weights), .s_valid(s_valid),
        .s_data(s_data), .s_ready(s_ready), .weight1(weight1),
        .weight2(weight2), .right_answer(right_answer),
        .enable(enable), .ex_we(ex_we), .ex_value(ex_value),
        .ex_addr(ex_addr), .bck_prop_start(bck_prop_start),
        .batch_end(batch_end), .all_end(all_end),
        .fc_bck_prop_end(fc_bck_prop_end),
        .fc_batch_end(fc_batch_end), .busy(busy), .done(done),
        .error(error), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    int mode = 0;
    int bp_delay = 3;
    bit ae_off = 1'b0;
    bit ign_pulse = 1'b0;
    bit clr_req = 1'b0;

    int ae_cnt = 0, bp_cnt = 0, be_cnt = 0;
    bit en_prev = 1'b0, tog = 1'b0;
    int n_w1, n_w2, n_in, n_ans, max_w1, run, last_cat;
    int mon_bad, bck_cnt, bend_cnt, done_cnt, gap_cnt;
    int checks = 0, errors = 0;

    // FC responder, stream source and monitor share one negedge process
    always @(negedge clk) begin
        all_end = 1'b0;
        fc_bck_prop_end = 1'b0;
        fc_batch_end = 1'b0;
        if (reset) begin
            ae_cnt = 0; bp_cnt = 0; be_cnt = 0; en_prev = 1'b0;
        end else begin
            if (ae_cnt > 0) begin
                ae_cnt--;
                if (ae_cnt == 0) all_end = 1'b1;
            end else if (enable && !en_prev && !ae_off) ae_cnt = 3;
            en_prev = enable;
            if (bp_cnt > 0) begin
                bp_cnt--;
                if (bp_cnt == 0) fc_bck_prop_end = 1'b1;
            end else if (bck_prop_start) begin
                if (bp_delay == 0) fc_bck_prop_end = 1'b1;
                else bp_cnt = bp_delay;
            end
            if (be_cnt > 0) begin
                be_cnt--;
                if (be_cnt == 0) fc_batch_end = 1'b1;
            end else if (batch_end) be_cnt = 3;
            if (ign_pulse) begin
                all_end = 1'b1; fc_bck_prop_end = 1'b1; fc_batch_end = 1'b1;
            end
        end
        tog = ~tog;
        s_valid = (mode == 1) || (mode == 2 && tog);
        s_data = s_data + 16'h0107;
        #1;
        if (clr_req) begin
            n_w1 = 0; n_w2 = 0; n_in = 0; n_ans = 0; max_w1 = -1;
            run = 0; last_cat = -1; mon_bad = 0; bck_cnt = 0;
            bend_cnt = 0; done_cnt = 0; gap_cnt = 0;
        end else begin
            if (ex_we === 1'b1) begin
                int cat;
                cat = weight1 ? 1 : weight2 ? 2 : right_answer ? 3 : 0;
                if (cat != last_cat) run = 0;
                if (ex_addr !== 16'(run)) mon_bad++;
                if (ex_value !== s_data) mon_bad++;
                case (cat)
                    1: begin n_w1++; max_w1 = int'(ex_addr); end
                    2: n_w2++;
                    3: n_ans++;
                    default: n_in++;
                endcase
                run++;
                last_cat = cat;
            end else if (ex_value !== 16'd0 || ex_addr !== 16'd0) mon_bad++;
            if (ex_we !== (s_valid && s_ready)) mon_bad++;
            if (int'(weight1) + int'(weight2) + int'(right_answer) + int'(enable) > 1)
                mon_bad++;
            if (s_ready && !s_valid) gap_cnt++;
            if (bck_prop_start) bck_cnt++;
            if (batch_end) bend_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_mon();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    task automatic pulse_start(input logic lw);
        start = 1'b1;
        load_weights = lw;
        tick();
        start = 1'b0;
        load_weights = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done_cnt > 0) break;
        end
        tick();
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL done_pulses got %0d want 1", done_cnt);
        end
    endtask

    task automatic wait_enable(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (enable === 1'b1) break;
            tick();
        end
        checks++;
        if (enable !== 1'b1) begin
            errors++;
            $display("FAIL enable_reached got %b want 1", enable);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, done, error, enable, s_ready, ex_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {busy, done, error, enable, s_ready, ex_we});
        end
        checks++;
        if ({weight1, weight2, right_answer, bck_prop_start, batch_end} !== 5'b0) begin
            errors++;
            $display("FAIL reset_sel got %b want 00000",
                     {weight1, weight2, right_answer, bck_prop_start, batch_end});
        end
        checks++;
        if (sample_cnt !== 6'd0 || ex_addr !== 16'd0 || ex_value !== 16'd0) begin
            errors++;
            $display("FAIL reset_data got cnt=%0d addr=%0d val=%0d want 0",
                     sample_cnt, ex_addr, ex_value);
        end
    endtask

    task automatic test_full_load();
        mode = 1;
        clear_mon();
        pulse_start(1'b1);
        wait_enable(400);
        checks++;
        if (n_w1 !== 140 || max_w1 !== 139) begin
            errors++;
            $display("FAIL w1_words got %0d last %0d want 140 last 139", n_w1, max_w1);
        end
        checks++;
        if (n_w2 !== 50 || n_in !== 14 || n_ans !== 5) begin
            errors++;
            $display("FAIL w2_in_ans got %0d/%0d/%0d want 50/14/5", n_w2, n_in, n_ans);
        end
        wait_done(2000);
        checks++;
        if (mon_bad !== 0) begin
            errors++;
            $display("FAIL full_load_stream got %0d bad want 0", mon_bad);
        end
        checks++;
        if (sample_cnt !== 6'(BS) || bck_cnt !== BS || bend_cnt !== 1) begin
            errors++;
            $display("FAIL full_load_batch got cnt=%0d bp=%0d be=%0d want %0d/%0d/1",
                     sample_cnt, bck_cnt, bend_cnt, BS, BS);
        end
    endtask

    task automatic test_batch();
        mode = 1;
        clear_mon();
        pulse_start(1'b0);
        repeat (30) tick();
        pulse_start(1'b1);
        wait_done(2000);
        checks++;
        if (n_w1 !== 0 || n_w2 !== 0) begin
            errors++;
            $display("FAIL batch_no_weights got %0d/%0d want 0/0", n_w1, n_w2);
        end
        checks++;
        if (n_in !== 14 * BS || n_ans !== 5 * BS) begin
            errors++;
            $display("FAIL batch_words got %0d/%0d want %0d/%0d",
                     n_in, n_ans, 14 * BS, 5 * BS);
        end
        checks++;
        if (bck_cnt !== BS || bend_cnt !== 1 || mon_bad !== 0) begin
            errors++;
            $display("FAIL batch_pulses got bp=%0d be=%0d bad=%0d want %0d/1/0",
                     bck_cnt, bend_cnt, mon_bad, BS);
        end
        repeat (5) tick();
        checks++;
        if (sample_cnt !== 6'(BS) || busy !== 1'b0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL batch_hold got cnt=%0d busy=%b done=%0d want %0d/0/1",
                     sample_cnt, busy, done_cnt, BS);
        end
    endtask

    task automatic test_ignore();
        ign_pulse = 1'b1;
        tick();
        ign_pulse = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || enable !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore got busy=%b en=%b done=%b want 0/0/0",
                     busy, enable, done);
        end
    endtask

    task automatic test_same_cycle_bprop();
        bp_delay = 0;
        mode = 1;
        clear_mon();
        pulse_start(1'b0);
        wait_done(2000);
        checks++;
        if (bck_cnt !== BS || sample_cnt !== 6'(BS)) begin
            errors++;
            $display("FAIL same_cycle_bprop got bp=%0d cnt=%0d want %0d/%0d",
                     bck_cnt, sample_cnt, BS, BS);
        end
        bp_delay = 3;
    endtask

    task automatic test_toggle();
        mode = 2;
        clear_mon();
        pulse_start(1'b0);
        wait_enable(200);
        checks++;
        if (n_in !== 14 || n_ans !== 5 || mon_bad !== 0) begin
            errors++;
            $display("FAIL toggle_load got in=%0d ans=%0d bad=%0d want 14/5/0",
                     n_in, n_ans, mon_bad);
        end
        checks++;
        if (gap_cnt < 14) begin
            errors++;
            $display("FAIL toggle_gaps got %0d want >=14", gap_cnt);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mode = 0;
    endtask

    task automatic test_reset_run();
        mode = 1;
        clear_mon();
        pulse_start(1'b0);
        for (int i = 0; i < 1000; i++) begin
            if (sample_cnt === 6'd5 && enable === 1'b1) break;
            tick();
        end
        checks++;
        if (sample_cnt !== 6'd5 || enable !== 1'b1) begin
            errors++;
            $display("FAIL reach_run5 got cnt=%0d en=%b want 5/1", sample_cnt, enable);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (enable !== 1'b0 || busy !== 1'b0 || sample_cnt !== 6'd0) begin
            errors++;
            $display("FAIL reset_in_run got en=%b busy=%b cnt=%0d want 0/0/0",
                     enable, busy, sample_cnt);
        end
        reset = 1'b0;
        clear_mon();
        pulse_start(1'b0);
        wait_done(2000);
        checks++;
        if (sample_cnt !== 6'(BS) || bck_cnt !== BS || mon_bad !== 0) begin
            errors++;
            $display("FAIL rerun_after_reset got cnt=%0d bp=%0d bad=%0d want %0d/%0d/0",
                     sample_cnt, bck_cnt, mon_bad, BS, BS);
        end
    endtask

`ifdef FC_SEQ_WATCHDOG_EN
    task automatic test_watchdog();
        mode = 1;
        ae_off = 1'b1;
        clear_mon();
        pulse_start(1'b0);
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (busy === 1'b0) break;
        end
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || done_cnt !== 0) begin
            errors++;
            $display("FAIL watchdog got err=%b busy=%b done=%0d want 1/0/0",
                     error, busy, done_cnt);
        end
        ae_off = 1'b0;
        pulse_start(1'b0);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_clear got %b want 0", error);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_batch();
        test_ignore();
        test_same_cycle_bprop();
        test_toggle();
        test_reset_run();
`ifdef FC_SEQ_WATCHDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
